// File: rtl/vec_ldst_if.sv
// vec_ldst_if
// Bundles everything between the vector load/store sequencer and its
// neighbours: the decoder's Start/Busy/Done command handshake, the serial
// port of the vector register file, and the 16-bit data memory port.
//
// Modports
//   master : the sequencer side (drives Busy/Done, register file and memory strobes)
//   slave  : the environment side (decoder, register file, data memory)
//
// Signals
//   Start, Op, VecAddr[2:0], BaseAddr[15:0]  command from the decoder
//   Busy, Done                               command status back to the decoder
//   Addr[2:0], WR_s, DataIn_s[15:0]          serial write into the register file
//   RD_s, DataOut_s[15:0]                    serial read from the register file
//   MemAddr[15:0], MemRD, MemWR              memory address and strobes
//   MemDataOut[15:0], MemDataIn[15:0]        memory write / read data
interface vec_ldst_if;
    logic        Start;
    logic        Op;
    logic [2:0]  VecAddr;
    logic [15:0] BaseAddr;
    logic        Busy;
    logic        Done;
    logic [2:0]  Addr;
    logic        WR_s;
    logic [15:0] DataIn_s;
    logic        RD_s;
    logic [15:0] DataOut_s;
    logic [15:0] MemAddr;
    logic        MemRD;
    logic        MemWR;
    logic [15:0] MemDataOut;
    logic [15:0] MemDataIn;

    modport master (
        input  Start, Op, VecAddr, BaseAddr, DataOut_s, MemDataIn,
        output Busy, Done, Addr, WR_s, DataIn_s, RD_s,
               MemAddr, MemRD, MemWR, MemDataOut
    );

    modport slave (
        output Start, Op, VecAddr, BaseAddr, DataOut_s, MemDataIn,
        input  Busy, Done, Addr, WR_s, DataIn_s, RD_s,
               MemAddr, MemRD, MemWR, MemDataOut
    );
endinterface

// File: rtl/vec_ldst.sv
// vec_ldst
// Vector load/store sequencer. A load reads 16 consecutive memory words and
// streams them into one vector register as a 16-beat serial write; a store
// streams a vector register out as a 16-beat serial read and writes the words
// to 16 consecutive memory locations. Address arithmetic wraps modulo 2^16.
//
// Parameters
//   RD_LAT : cycles from the k-th RD_s-high cycle until element k is valid
//            on DataOut_s (1..4)
//
// Ports
//   Clk1  : sole clock, rising edge
//   Rst_n : asynchronous active-low reset
//   bus   : vec_ldst_if master modport (command handshake, register file
//           serial port, data memory port)
//
// Every output is a register. Each transition therefore writes the values
// the outputs must carry in the *next* cycle, which is why the window
// comparisons below are offset by one from the cycle numbers they produce.
module vec_ldst #(
    parameter int RD_LAT = 2
) (
    input  logic       Clk1,
    input  logic       Rst_n,
    vec_ldst_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STORE,
        DONE
    } state_t;

    localparam logic [4:0] LAST_BEAT  = 5'd15;
    localparam logic [4:0] LOAD_LAST  = 5'd17;
    localparam logic [4:0] LAT        = 5'(RD_LAT);
    localparam logic [4:0] STORE_WR_E = 5'(RD_LAT + 15);
    localparam logic [4:0] STORE_LAST = 5'(RD_LAT + 16);

    state_t      state;
    logic [4:0]  cnt;
    logic [15:0] base_q;

    logic [4:0]  cnt_next;
    logic [4:0]  store_idx;
    logic        load_capture;
    logic        store_capture;

    assign cnt_next      = cnt + 5'd1;
    // Element of the vector that is on DataOut_s during this store cycle.
    assign store_idx     = cnt - LAT;
    // Memory data for element cnt-1 is on MemDataIn during cycles 1..16.
    assign load_capture  = (cnt >= 5'd1) && (cnt <= 5'd16);
    assign store_capture = (cnt >= LAT) && (cnt <= STORE_WR_E);

    // The op is not kept in a separate register: LOAD and STORE are
    // distinct states, so the accepted Op lives in the state itself.
    always_ff @(posedge Clk1 or negedge Rst_n) begin
        if (!Rst_n) begin
            state          <= IDLE;
            cnt            <= 5'd0;
            base_q         <= 16'd0;
            bus.Busy       <= 1'b0;
            bus.Done       <= 1'b0;
            bus.Addr       <= 3'd0;
            bus.WR_s       <= 1'b0;
            bus.DataIn_s   <= 16'd0;
            bus.RD_s       <= 1'b0;
            bus.MemAddr    <= 16'd0;
            bus.MemRD      <= 1'b0;
            bus.MemWR      <= 1'b0;
            bus.MemDataOut <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    bus.Done <= 1'b0;
                    if (bus.Start) begin
                        base_q   <= bus.BaseAddr;
                        bus.Addr <= bus.VecAddr;
                        bus.Busy <= 1'b1;
                        cnt      <= 5'd0;
                        if (!bus.Op) begin
                            // First read goes out in the very first LOAD cycle.
                            state       <= LOAD;
                            bus.MemRD   <= 1'b1;
                            bus.MemAddr <= bus.BaseAddr;
                        end else begin
                            state    <= STORE;
                            bus.RD_s <= 1'b1;
                        end
                    end
                end

                LOAD: begin
                    cnt       <= cnt_next;
                    bus.MemRD <= (cnt < LAST_BEAT);
                    if (cnt < LAST_BEAT) begin
                        bus.MemAddr <= base_q + {11'd0, cnt_next};
                    end
                    bus.WR_s <= load_capture;
                    if (load_capture) begin
                        bus.DataIn_s <= bus.MemDataIn;
                    end
                    if (cnt == LOAD_LAST) begin
                        state    <= DONE;
                        bus.Done <= 1'b1;
                        cnt      <= 5'd0;
                    end
                end

                STORE: begin
                    cnt      <= cnt_next;
                    bus.RD_s <= (cnt < LAST_BEAT);
                    if (store_capture) begin
                        bus.MemWR      <= 1'b1;
                        bus.MemAddr    <= base_q + {11'd0, store_idx};
                        bus.MemDataOut <= bus.DataOut_s;
                    end else begin
                        bus.MemWR <= 1'b0;
                    end
                    if (cnt == STORE_LAST) begin
                        state    <= DONE;
                        bus.Done <= 1'b1;
                        cnt      <= 5'd0;
                    end
                end

                DONE: begin
                    // Start is deliberately not looked at here.
                    state    <= IDLE;
                    bus.Done <= 1'b0;
                    bus.Busy <= 1'b0;
                    cnt      <= 5'd0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_ldst.sv
// tb_vec_ldst
// Bench for vec_ldst. Emulates the data memory and the vector register file
// around the DUT, keeps a reference model of memory/register contents and of
// the per-cycle output windows of a command, and compares every output on
// every falling edge. Directed commands add hand-computed literal checks.
module tb_vec_ldst;

    localparam int RD_LAT = 2;

    logic Clk1  = 1'b0;
    logic Rst_n = 1'b1;

    vec_ldst_if bus();

    vec_ldst #(.RD_LAT(RD_LAT)) dut (
        .Clk1  (Clk1),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    always #5 Clk1 = ~Clk1;

    int check_count = 0;
    int pass_count  = 0;
    int cyc         = 0;
    int done_seen   = 0;

    logic [15:0] emu_mem [65536];
    logic [15:0] ref_mem [65536];
    logic [15:0] emu_vrf [8][16];
    logic [15:0] ref_vrf [8][16];
    logic [15:0] rd_addr_log [$];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [63:0] pack_outputs();
        return {7'd0, bus.Busy, bus.Done, bus.MemRD, bus.MemWR, bus.RD_s, bus.WR_s,
                bus.Addr, bus.MemAddr, bus.MemDataOut, bus.DataIn_s};
    endfunction

    // Memory and register file emulation. Outputs of the DUT are read in the
    // active region of the edge (old values); responses go out as NBAs.
    logic        wr_prev = 1'b0;
    logic        rd_prev = 1'b0;
    logic [4:0]  wr_idx  = 5'd0;
    logic [4:0]  rd_idx  = 5'd0;
    logic [15:0] rd_pipe [1:RD_LAT];

    always @(posedge Clk1) begin
        cyc++;
        if (!Rst_n) begin
            wr_prev = 1'b0;
            rd_prev = 1'b0;
        end else begin
            bus.MemDataIn <= bus.MemRD ? emu_mem[bus.MemAddr] : 16'hDEAD;
            if (bus.MemWR) emu_mem[bus.MemAddr] <= bus.MemDataOut;
            if (bus.WR_s) begin
                if (!wr_prev) wr_idx = 5'd0;
                if (wr_idx < 5'd16) emu_vrf[bus.Addr][wr_idx[3:0]] <= bus.DataIn_s;
                wr_idx = wr_idx + 5'd1;
            end
            wr_prev = bus.WR_s;
            for (int i = RD_LAT; i > 1; i--) rd_pipe[i] = rd_pipe[i-1];
            if (bus.RD_s) begin
                if (!rd_prev) rd_idx = 5'd0;
                rd_pipe[1] = (rd_idx < 5'd16) ? emu_vrf[bus.Addr][rd_idx[3:0]] : 16'hDEAD;
                rd_idx = rd_idx + 5'd1;
            end else begin
                rd_pipe[1] = 16'hDEAD;
            end
            rd_prev = bus.RD_s;
            bus.DataOut_s <= rd_pipe[RD_LAT];
        end
    end

    // Reference model: phase 0 idle, 1 transferring (m_c = cycle in op), 2 done.
    int          m_phase = 0;
    int          m_c     = 0;
    logic        m_op    = 1'b0;
    logic [2:0]  m_vec   = 3'd0;
    logic [15:0] m_base  = 16'd0;
    logic [2:0]  e_addr     = 3'd0;
    logic [15:0] e_mem_addr = 16'd0;
    logic [15:0] e_mem_dout = 16'd0;
    logic [15:0] e_din      = 16'd0;

    always @(negedge Clk1) begin
        logic e_busy, e_done, e_mrd, e_mwr, e_rd, e_wr;
        logic [3:0] k;
        if (bus.Done) done_seen++;
        if (bus.MemRD) rd_addr_log.push_back(bus.MemAddr);
        if (!Rst_n) begin
            m_phase    = 0;
            e_addr     = 3'd0;
            e_mem_addr = 16'd0;
            e_mem_dout = 16'd0;
            e_din      = 16'd0;
        end
        e_busy = (m_phase != 0);
        e_done = (m_phase == 2);
        e_mrd = 1'b0; e_mwr = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
        if (m_phase == 1 && !m_op) begin
            e_mrd = (m_c <= 15);
            if (e_mrd) e_mem_addr = m_base + 16'(m_c);
            e_wr = (m_c >= 2) && (m_c <= 17);
            if (e_wr) e_din = ref_mem[m_base + 16'(m_c - 2)];
        end
        if (m_phase == 1 && m_op) begin
            e_rd  = (m_c <= 15);
            e_mwr = (m_c >= RD_LAT + 1) && (m_c <= RD_LAT + 16);
            if (e_mwr) begin
                k = 4'(m_c - RD_LAT - 1);
                e_mem_addr = m_base + {12'd0, k};
                e_mem_dout = ref_vrf[m_vec][k];
            end
        end
        checkOutput("Busy",       64'(bus.Busy),       64'(e_busy));
        checkOutput("Done",       64'(bus.Done),       64'(e_done));
        checkOutput("MemRD",      64'(bus.MemRD),      64'(e_mrd));
        checkOutput("MemWR",      64'(bus.MemWR),      64'(e_mwr));
        checkOutput("RD_s",       64'(bus.RD_s),       64'(e_rd));
        checkOutput("WR_s",       64'(bus.WR_s),       64'(e_wr));
        checkOutput("Addr",       64'(bus.Addr),       64'(e_addr));
        checkOutput("MemAddr",    64'(bus.MemAddr),    64'(e_mem_addr));
        checkOutput("MemDataOut", 64'(bus.MemDataOut), 64'(e_mem_dout));
        checkOutput("DataIn_s",   64'(bus.DataIn_s),   64'(e_din));
        if (Rst_n) begin
            case (m_phase)
                0: if (bus.Start) begin
                    m_phase = 1;
                    m_c     = 0;
                    m_op    = bus.Op;
                    m_vec   = bus.VecAddr;
                    m_base  = bus.BaseAddr;
                    e_addr  = bus.VecAddr;
                end
                1: if (m_c == (m_op ? RD_LAT + 16 : 17)) begin
                    m_phase = 2;
                    for (int j = 0; j < 16; j++) begin
                        if (!m_op) ref_vrf[m_vec][j] = ref_mem[m_base + 16'(j)];
                        else       ref_mem[m_base + 16'(j)] = ref_vrf[m_vec][j];
                    end
                end else begin
                    m_c++;
                end
                default: m_phase = 0;
            endcase
        end
    end

    task automatic applyStimulus(input logic op, input logic [2:0] vec, input logic [15:0] base,
                                 output int start_cyc);
        bus.Start    = 1'b1;
        bus.Op       = op;
        bus.VecAddr  = vec;
        bus.BaseAddr = base;
        @(posedge Clk1); #1;
        start_cyc = cyc;
        bus.Start = 1'b0;
    endtask

    // Returns inside the Done cycle; lat counts cycles c=0..Done inclusive.
    task automatic waitDone(input int start_cyc, output int lat);
        int guard = 0;
        lat = -1;
        while (!bus.Done && guard < 100) begin
            @(posedge Clk1); #1;
            guard++;
        end
        if (bus.Done) lat = cyc - start_cyc + 1;
        else checkOutput("done_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        int s, lat, d0;
        for (int i = 0; i < 65536; i++) begin
            emu_mem[i] = 16'(i) ^ 16'h5A5A;
            ref_mem[i] = 16'(i) ^ 16'h5A5A;
        end
        for (int k = 0; k < 16; k++) begin
            emu_mem[16'h0100 + k] = 16'hA000 + 16'(k);
            ref_mem[16'h0100 + k] = 16'hA000 + 16'(k);
        end
        for (int v = 0; v < 8; v++)
            for (int k = 0; k < 16; k++) begin
                emu_vrf[v][k] = (v == 5) ? 16'hB000 + 16'(k) : 16'h0000;
                ref_vrf[v][k] = (v == 5) ? 16'hB000 + 16'(k) : 16'h0000;
            end
        bus.Start = 1'b0; bus.Op = 1'b0; bus.VecAddr = 3'd0; bus.BaseAddr = 16'd0;

        #2 Rst_n = 1'b0;
        repeat (3) @(posedge Clk1); #1;
        checkOutput("reset_outputs", pack_outputs(), 64'd0);
        Rst_n = 1'b1;
        @(posedge Clk1); #1;

        // Load into v3 with a store request during the load and one in DONE.
        d0 = done_seen;
        applyStimulus(1'b0, 3'd3, 16'h0100, s);
        repeat (5) @(posedge Clk1); #1;
        bus.Start = 1'b1; bus.Op = 1'b1; bus.VecAddr = 3'd7; bus.BaseAddr = 16'h3000;
        @(posedge Clk1); #1;
        bus.Start = 1'b0;
        waitDone(s, lat);
        checkOutput("load_latency", 64'(lat), 64'(19));
        bus.Start = 1'b1;
        @(posedge Clk1); #1;
        bus.Start = 1'b0;
        repeat (3) @(posedge Clk1); #1;
        checkOutput("load_single_done", 64'(done_seen - d0), 64'(1));
        checkOutput("load_idle_busy", 64'(bus.Busy), 64'(0));
        checkOutput("load_addr_held", 64'(bus.Addr), 64'(3));
        checkOutput("reject_no_mem_write", 64'(emu_mem[16'h3000]), 64'h6A5A);
        for (int k = 0; k < 16; k++)
            checkOutput("load_v3_elem", 64'(emu_vrf[3][k]), 64'(16'hA000 + 16'(k)));

        // Store v5 to 0x2000.
        applyStimulus(1'b1, 3'd5, 16'h2000, s);
        waitDone(s, lat);
        checkOutput("store_latency", 64'(lat), 64'(RD_LAT + 18));
        repeat (2) @(posedge Clk1); #1;
        for (int k = 0; k < 16; k++)
            checkOutput("store_mem", 64'(emu_mem[16'h2000 + k]), 64'(16'hB000 + 16'(k)));

        // Load across the top of the address space.
        rd_addr_log.delete();
        applyStimulus(1'b0, 3'd1, 16'hFFF8, s);
        waitDone(s, lat);
        checkOutput("wrap_latency", 64'(lat), 64'(19));
        repeat (2) @(posedge Clk1); #1;
        checkOutput("wrap_rd_count", 64'(rd_addr_log.size()), 64'(16));
        if (rd_addr_log.size() == 16) begin
            checkOutput("wrap_addr0",  64'(rd_addr_log[0]),  64'hFFF8);
            checkOutput("wrap_addr7",  64'(rd_addr_log[7]),  64'hFFFF);
            checkOutput("wrap_addr8",  64'(rd_addr_log[8]),  64'h0000);
            checkOutput("wrap_addr15", 64'(rd_addr_log[15]), 64'h0007);
        end
        checkOutput("wrap_v1_elem0", 64'(emu_vrf[1][0]), 64'hA5A2);
        checkOutput("wrap_v1_elem8", 64'(emu_vrf[1][8]), 64'h5A5A);

        // Reset in cycle 7 of a load, then a clean load.
        d0 = done_seen;
        applyStimulus(1'b0, 3'd6, 16'h0100, s);
        repeat (7) @(posedge Clk1); #1;
        Rst_n = 1'b0;
        #1;
        checkOutput("reset_midop_outputs", pack_outputs(), 64'd0);
        repeat (2) @(posedge Clk1); #1;
        Rst_n = 1'b1;
        @(posedge Clk1); #1;
        checkOutput("reset_no_done", 64'(done_seen - d0), 64'(0));
        applyStimulus(1'b0, 3'd6, 16'h0100, s);
        waitDone(s, lat);
        checkOutput("reload_latency", 64'(lat), 64'(19));
        repeat (2) @(posedge Clk1); #1;
        for (int k = 0; k < 16; k++)
            checkOutput("reload_v6_elem", 64'(emu_vrf[6][k]), 64'(16'hA000 + 16'(k)));

        // Back-to-back load then store of the same vector.
        applyStimulus(1'b0, 3'd2, 16'h0100, s);
        waitDone(s, lat);
        checkOutput("b2b_load_latency", 64'(lat), 64'(19));
        @(posedge Clk1); #1;
        applyStimulus(1'b1, 3'd2, 16'h4000, s);
        waitDone(s, lat);
        checkOutput("b2b_store_latency", 64'(lat), 64'(RD_LAT + 18));
        repeat (2) @(posedge Clk1); #1;
        for (int k = 0; k < 16; k++)
            checkOutput("b2b_copy", 64'(emu_mem[16'h4000 + k]), 64'(16'hA000 + 16'(k)));

        repeat (2) @(posedge Clk1); #1;
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
